microwave_timer_sequencer: RTL and testbench
============================================

// Module: microwave_timer_sequencer
// PURPOSE
//  Sequences the keypad/timer front end of the microwave controller. Shifts keypad BCD digits into a
//  M:SS register, counts down once per 1 Hz tick while cooking, and drives magnetron/done outputs.
//  Drives enable_n back to the timer input stage to choose its mode: 0 = keypad entry, 1 = 1 Hz countdown.
// PARAMETERS
//  DONE_SECONDS  3  number of pgt_1Hz ticks that done stays high after the count reaches 0:00
// PORTS
//  clock      in   1  system clock (100 Hz domain); all logic on its rising edge
//  clear      in   1  synchronous, active-high reset
//  D          in   4  BCD digit from the keypad encoder
//  load_n     in   1  active-low digit-valid from the keypad encoder
//  pgt_1Hz    in   1  tick/strobe from the timer input stage (level signal; edge-detected here)
//  start      in   1  start request, active-high level
//  stop       in   1  stop/cancel request, active-high level
//  door_closed in  1  1 = door shut
//  enable_n   out  1  0 = keypad entry enabled; 1 = cooking, selects 1 Hz tick upstream
//  min_ones   out  4  BCD minutes digit (0-9)
//  sec_tens   out  4  BCD tens-of-seconds digit (0-5)
//  sec_ones   out  4  BCD seconds digit (0-9)
//  mag_on     out  1  magnetron enable
//  done       out  1  cook-complete indicator
// BEHAVIOUR
//  Reset (clear=1 at clock edge): state=IDLE; digits=0:00; enable_n=0; mag_on=0; done=0; edge registers=1/0.
//  Edge detect: registered copies of load_n and pgt_1Hz.
//   load_ev = prev_load_n & ~load_n.  tick_ev = ~prev_pgt & pgt_1Hz.
//   Each event is a single-cycle pulse, seen one cycle after the input edge.
//  States: IDLE (entry), COOK, PAUSE, DONE.
//  Request priority within a cycle: clear > stop > door open > start > load_ev/tick_ev.
//  IDLE: enable_n=0, mag_on=0.
//   load_ev with D<=9 shifts the digits left: min_ones<=sec_tens; sec_tens<=sec_ones; sec_ones<=D.
//   D>9 is ignored. A sec_tens value >5 after a shift is accepted, then normalised on the first tick (see COOK).
//   start & door_closed & time!=0:00 -> COOK.
//   start while time==0:00 or door open: ignored, stay in IDLE.
//   stop -> digits=0:00, stay in IDLE.
//  COOK: enable_n=1, mag_on=1. load_ev is ignored.
//   tick_ev performs a BCD decrement:
//    sec_ones 0 -> 9 with borrow;
//    sec_tens 0 -> 5 with borrow; sec_tens >5 -> 5 (normalise, no borrow);
//    min_ones decrements on borrow.
//   Decrement reaching 0:00 -> DONE in the same edge; mag_on falls in the next cycle.
//   ~door_closed -> PAUSE (mag_on=0 from next cycle; digits held).
//   stop -> PAUSE.
//   A tick in the same cycle as door-open/stop is discarded.
//  PAUSE: enable_n=0 (keypad live but load_ev ignored), mag_on=0, digits held.
//   start & door_closed -> COOK.
//   stop -> digits=0:00, IDLE.
//  DONE: done=1, enable_n=1, mag_on=0. Counts tick_ev.
//   After DONE_SECONDS ticks -> IDLE, done=0.
//   stop -> IDLE immediately.
//   start and load_ev are ignored.
//  clear mid-cook: next cycle is fully reset, with mag_on=0.
//  Outputs are registered; no combinational input-to-output path.
// STRUCTURE
//  Shared package: state localparams, BCD_W=4, SEC_TENS_MAX=5, BCD_MAX=9.
//  One sub-module: bcd_mmss_down_counter.
//   Ports: clock, clear, shift, shift_digit, dec, digits out, zero flag.
//   Holds the shift and decrement datapath; the FSM stays in this module.
// TESTING
//  1. Entry: load D=1,3,0 -> digits 1:30 after third load_ev; D=12 in between -> no change.
//  2. Countdown: 0:02, start, door closed -> mag_on=1, enable_n=1; 2 ticks -> 0:00, done=1, mag_on=0;
//     DONE_SECONDS ticks later -> IDLE, done=0.
//  3. Borrow: 1:00 then one tick -> 0:59. Entry 0:75 then one tick -> 0:59 (normalise; 0:75 is not decremented to 0:74).
//  4. Door: open during COOK at 0:10 -> PAUSE, digits frozen through ticks;
//     close + start -> COOK resumes from 0:10.
//  5. Guards: start at 0:00 or door open -> stays IDLE. stop in PAUSE -> 0:00 IDLE.
//     stop + start in the same cycle -> stop wins.
//  6. Reset mid-cook at 0:45: clear one cycle -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/microwave_timer_sequencer_pkg.sv
// Shared types and constants for the microwave keypad/timer sequencer.
// Latency: n/a (types only); backpressure: n/a.
package microwave_timer_sequencer_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int BCD_MAX      = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } mmss_t;

    // True when one more decrement lands exactly on 0:00.
    function automatic logic dec_hits_zero(input mmss_t t);
        return (t.min_ones == '0) && (t.sec_tens == '0) && (t.sec_ones == BCD_W'(1));
    endfunction

endpackage

// File: rtl/microwave_timer_sequencer_if.sv
// Keypad/timer front-end bundle between the input stage and the sequencer.
// Latency: wires only; backpressure: none (strobes are edge-detected by the slave).
interface microwave_timer_sequencer_if;
    import microwave_timer_sequencer_pkg::*;

    logic [BCD_W-1:0] D;
    logic             load_n;
    logic             pgt_1Hz;
    logic             start;
    logic             stop;
    logic             door_closed;
    logic             enable_n;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             mag_on;
    logic             done;

    modport master (
        output D, load_n, pgt_1Hz, start, stop, door_closed,
        input  enable_n, min_ones, sec_tens, sec_ones, mag_on, done
    );

    modport slave (
        input  D, load_n, pgt_1Hz, start, stop, door_closed,
        output enable_n, min_ones, sec_tens, sec_ones, mag_on, done
    );
endinterface

// File: rtl/microwave_timer_sequencer_bcd_mmss_down_counter.sv
// M:SS BCD register: left-shift keypad entry and one-second BCD decrement.
// Latency: 1 cycle from shift/dec to digits; backpressure: none.
module bcd_mmss_down_counter
    import microwave_timer_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             shift,
    input  logic [BCD_W-1:0] shift_digit,
    input  logic             dec,
    output mmss_t            digits,
    output logic             zero
);
    mmss_t digits_q, digits_d;

    always_comb begin
        digits_d = digits_q;
        if (shift) begin
            digits_d.min_ones = digits_q.sec_tens;
            digits_d.sec_tens = digits_q.sec_ones;
            digits_d.sec_ones = shift_digit;
        end else if (dec && !zero) begin
            // An out-of-range tens digit (e.g. 0:75) collapses to :59 rather than counting.
            if (digits_q.sec_tens > BCD_W'(SEC_TENS_MAX)) begin
                digits_d.sec_tens = BCD_W'(SEC_TENS_MAX);
                digits_d.sec_ones = BCD_W'(BCD_MAX);
            end else if (digits_q.sec_ones != '0) begin
                digits_d.sec_ones = digits_q.sec_ones - BCD_W'(1);
            end else begin
                digits_d.sec_ones = BCD_W'(BCD_MAX);
                if (digits_q.sec_tens != '0) begin
                    digits_d.sec_tens = digits_q.sec_tens - BCD_W'(1);
                end else begin
                    digits_d.sec_tens = BCD_W'(SEC_TENS_MAX);
                    digits_d.min_ones = digits_q.min_ones - BCD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

    assign digits = digits_q;
    assign zero   = (digits_q == '0);
endmodule

// File: rtl/microwave_timer_sequencer.sv
// Microwave keypad/timer sequencer: entry, countdown, pause and done hold-off FSM.
// Latency: events act one edge after detection, outputs registered; backpressure: none.
module microwave_timer_sequencer
    import microwave_timer_sequencer_pkg::*;
#(
    parameter int DONE_SECONDS = 3
) (
    input  logic                       clock,
    input  logic                       clear,
    microwave_timer_sequencer_if.slave bus
);
    localparam int CNT_W = (DONE_SECONDS > 1) ? $clog2(DONE_SECONDS) : 1;

    state_t           state_q, state_d;
    logic             prev_load_n_q, prev_load_n_d;
    logic             prev_pgt_q, prev_pgt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic             enable_n_q, enable_n_d;
    logic             mag_on_q, mag_on_d;
    logic             done_q, done_d;

    logic  load_ev, tick_ev;
    logic  shift, dec, clr_digits, zero;
    mmss_t digits;

    assign load_ev = prev_load_n_q & ~bus.load_n;
    assign tick_ev = ~prev_pgt_q & bus.pgt_1Hz;

    bcd_mmss_down_counter u_counter (
        .clock       (clock),
        .clear       (clear | clr_digits),
        .shift       (shift),
        .shift_digit (bus.D),
        .dec         (dec),
        .digits      (digits),
        .zero        (zero)
    );

    always_comb begin
        state_d       = state_q;
        done_cnt_d    = '0;
        shift         = 1'b0;
        dec           = 1'b0;
        clr_digits    = 1'b0;
        prev_load_n_d = bus.load_n;
        prev_pgt_d    = bus.pgt_1Hz;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.stop) begin
                    clr_digits = 1'b1;
                end else if (bus.start) begin
                    if (bus.door_closed && !zero) state_d = ST_COOK;
                end else if (load_ev && (bus.D <= BCD_W'(BCD_MAX))) begin
                    shift = 1'b1;
                end
            end
            ST_COOK: begin
                // Stop and door-open both swallow a coincident tick.
                if (bus.stop || !bus.door_closed) begin
                    state_d = ST_PAUSE;
                end else if (tick_ev) begin
                    dec = 1'b1;
                    if (dec_hits_zero(digits)) state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    clr_digits = 1'b1;
                    state_d    = ST_IDLE;
                end else if (bus.start && bus.door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                done_cnt_d = done_cnt_q;
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (tick_ev) begin
                    if (done_cnt_q == CNT_W'(DONE_SECONDS - 1)) begin
                        state_d    = ST_IDLE;
                        done_cnt_d = '0;
                    end else begin
                        done_cnt_d = done_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        enable_n_d = (state_d == ST_COOK) || (state_d == ST_DONE);
        mag_on_d   = (state_d == ST_COOK);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= ST_IDLE;
            prev_load_n_q <= 1'b1;
            prev_pgt_q    <= 1'b0;
            done_cnt_q    <= '0;
            enable_n_q    <= 1'b0;
            mag_on_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_load_n_q <= prev_load_n_d;
            prev_pgt_q    <= prev_pgt_d;
            done_cnt_q    <= done_cnt_d;
            enable_n_q    <= enable_n_d;
            mag_on_q      <= mag_on_d;
            done_q        <= done_d;
        end
    end

    assign bus.enable_n = enable_n_q;
    assign bus.mag_on   = mag_on_q;
    assign bus.done     = done_q;
    assign bus.min_ones = digits.min_ones;
    assign bus.sec_tens = digits.sec_tens;
    assign bus.sec_ones = digits.sec_ones;
endmodule

// File: tb/tb_microwave_timer_sequencer.sv
// Scenario bench for the microwave sequencer: expected output snapshots are queued at
// each stimulus step together with the observed outputs, then drained and compared per scenario.
module tb_microwave_timer_sequencer;
    logic clock;
    logic clear;

    microwave_timer_sequencer_if dut_if ();

    microwave_timer_sequencer #(.DONE_SECONDS(3)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (dut_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    string       sb_name[$];
    logic [14:0] sb_exp[$];
    logic [14:0] sb_obs[$];

    // {enable_n, mag_on, done, min_ones, sec_tens, sec_ones}
    function automatic logic [14:0] pk(input logic en, input logic mag, input logic dn,
                                       input int m, input int t, input int o);
        return {en, mag, dn, 4'(m), 4'(t), 4'(o)};
    endfunction

    function automatic logic [14:0] obs();
        return {dut_if.enable_n, dut_if.mag_on, dut_if.done,
                dut_if.min_ones, dut_if.sec_tens, dut_if.sec_ones};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap(input string nm, input logic [14:0] e);
        sb_name.push_back(nm);
        sb_exp.push_back(e);
        sb_obs.push_back(obs());
    endtask

    task automatic key(input int d);
        dut_if.D = 4'(d);
        dut_if.load_n = 1'b0;
        cyc(1);
        dut_if.load_n = 1'b1;
        cyc(1);
    endtask

    task automatic tick();
        dut_if.pgt_1Hz = 1'b1;
        cyc(1);
        dut_if.pgt_1Hz = 1'b0;
        cyc(1);
    endtask

    task automatic press_start();
        dut_if.start = 1'b1;
        cyc(1);
        dut_if.start = 1'b0;
        cyc(1);
    endtask

    task automatic clr_time();
        dut_if.stop = 1'b1;
        cyc(2);
        dut_if.stop = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        cyc(2);
        clear = 1'b0;
        cyc(1);
        snap("reset", pk(0, 0, 0, 0, 0, 0));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    task automatic test_entry();
        clr_time();
        key(1);  snap("entry_1",    pk(0, 0, 0, 0, 0, 1));
        key(12); snap("entry_d12",  pk(0, 0, 0, 0, 0, 1));
        key(3);  snap("entry_13",   pk(0, 0, 0, 0, 1, 3));
        key(0);  snap("entry_130",  pk(0, 0, 0, 1, 3, 0));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    task automatic test_countdown();
        int k;
        clr_time();
        key(0); key(2);
        press_start();
        snap("cook_start", pk(1, 1, 0, 0, 0, 2));
        tick();
        snap("cook_001",   pk(1, 1, 0, 0, 0, 1));
        dut_if.pgt_1Hz = 1'b1;
        cyc(1);
        dut_if.pgt_1Hz = 1'b0;
        k = 0;
        while (dut_if.done !== 1'b1 && k < 8) begin cyc(1); k++; end
        snap("done_on",    pk(1, 0, 1, 0, 0, 0));
        cyc(1);
        tick(); tick();
        snap("done_hold",  pk(1, 0, 1, 0, 0, 0));
        tick();
        snap("done_off",   pk(0, 0, 0, 0, 0, 0));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    task automatic test_borrow();
        clr_time();
        key(1); key(0); key(0);
        press_start();
        tick();
        snap("borrow_100", pk(1, 1, 0, 0, 5, 9));
        clr_time();
        key(0); key(7); key(5);
        snap("entry_075",  pk(0, 0, 0, 0, 7, 5));
        press_start();
        tick();
        snap("norm_075",   pk(1, 1, 0, 0, 5, 9));
        tick();
        snap("after_norm", pk(1, 1, 0, 0, 5, 8));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    task automatic test_door();
        clr_time();
        key(1); key(0);
        press_start();
        dut_if.door_closed = 1'b0;
        cyc(1);
        snap("door_pause",   pk(0, 0, 0, 0, 1, 0));
        tick(); tick();
        snap("pause_frozen", pk(0, 0, 0, 0, 1, 0));
        key(5);
        snap("pause_nokey",  pk(0, 0, 0, 0, 1, 0));
        press_start();
        snap("start_open",   pk(0, 0, 0, 0, 1, 0));
        dut_if.door_closed = 1'b1;
        press_start();
        snap("resume",       pk(1, 1, 0, 0, 1, 0));
        tick();
        snap("resume_tick",  pk(1, 1, 0, 0, 0, 9));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    task automatic test_guards();
        clr_time();
        press_start();
        snap("start_zero",  pk(0, 0, 0, 0, 0, 0));
        key(5);
        dut_if.door_closed = 1'b0;
        press_start();
        snap("start_door",  pk(0, 0, 0, 0, 0, 5));
        dut_if.door_closed = 1'b1;
        press_start();
        dut_if.stop = 1'b1;
        cyc(1);
        dut_if.stop = 1'b0;
        cyc(1);
        snap("stop_pause",  pk(0, 0, 0, 0, 0, 5));
        dut_if.stop = 1'b1;
        cyc(1);
        dut_if.stop = 1'b0;
        cyc(1);
        snap("stop_idle",   pk(0, 0, 0, 0, 0, 0));
        key(3);
        dut_if.stop = 1'b1;
        dut_if.start = 1'b1;
        cyc(1);
        dut_if.stop = 1'b0;
        dut_if.start = 1'b0;
        cyc(1);
        snap("stop_wins",   pk(0, 0, 0, 0, 0, 0));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    task automatic test_clear_midcook();
        clr_time();
        key(4); key(5);
        press_start();
        snap("cook_045",   pk(1, 1, 0, 0, 4, 5));
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        snap("clear_cook", pk(0, 0, 0, 0, 0, 0));
        tick();
        snap("clear_idle", pk(0, 0, 0, 0, 0, 0));
        while (sb_exp.size() > 0) begin
            logic [14:0] e, o;
            string nm;
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
        end
    endtask

    initial begin
        clear              = 1'b1;
        dut_if.D           = 4'd0;
        dut_if.load_n      = 1'b1;
        dut_if.pgt_1Hz     = 1'b0;
        dut_if.start       = 1'b0;
        dut_if.stop        = 1'b0;
        dut_if.door_closed = 1'b1;
        cyc(1);
        test_reset();
        test_entry();
        test_countdown();
        test_borrow();
        test_door();
        test_guards();
        test_clear_midcook();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
